// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared encodings for the watch front-end controller
package watch_pkg;

  localparam logic [1:0] MODE_CLOCK = 2'b00;
  localparam logic [1:0] MODE_STOPW = 2'b01;
  localparam logic [1:0] MODE_TIMER = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2
  } alarm_state_e;

  localparam int NUM_BTNS  = 5;
  localparam int BTN_MODE  = 0;
  localparam int BTN_START = 1;
  localparam int BTN_A     = 2;
  localparam int BTN_B     = 3;
  localparam int BTN_CLR   = 4;

  // Display mode rotation: clock -> stopwatch -> timer -> clock.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_CLOCK: next_mode = MODE_STOPW;
      MODE_STOPW: next_mode = MODE_TIMER;
      default:    next_mode = MODE_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - button synchronizer, debouncer and press pulse
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer for the asynchronous board button.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement; flip the level once stable long enough.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state and the one-cycle rising-edge press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/watch_ctrl.sv
// rtl/watch_ctrl.sv - watch front-end: buttons, 1 Hz tick, mode select, alarm FSM
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ALARM_SECS      = 10
) (
  input  logic       clk100MHz,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_clr,
  input  logic       timer_zero,
  input  logic       timer_running,
  output logic [1:0] sel,
  output logic       tick1s,
  output logic       start_p,
  output logic       a_p,
  output logic       b_p,
  output logic       clr_p,
  output logic       alarm,
  output logic       ringing
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF  = PW'(CLK_HZ / 2);
  localparam logic [RW-1:0] RING_LAST = RW'(ALARM_SECS - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;
  logic                any_press;
  logic                tick;

  logic [PW-1:0] pre_q, pre_d;
  logic [RW-1:0] ring_q, ring_d;
  logic [1:0]    sel_q, sel_d;
  alarm_state_e  state_q, state_d;
  logic          start_q, start_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          clr_q, clr_d;

  assign btn_raw = {btn_clr, btn_b, btn_a, btn_start, btn_mode};

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk_i  (clk100MHz),
      .rst_ni (rst_n),
      .btn_i  (btn_raw[gi]),
      .press_o(press[gi])
    );
  end

  assign any_press = |press;
  assign tick      = (pre_q == PRE_MAX);

  // Free-running prescaler, only reset clears it.
  always_comb begin
    pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
  end

  // Press routing, mode rotation and alarm FSM; an acknowledging press is swallowed.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ring_d  = ring_q;
    start_d = 1'b0;
    a_d     = 1'b0;
    b_d     = 1'b0;
    clr_d   = 1'b0;
    if ((state_q == RINGING) && any_press) begin
      state_d = IDLE;
      ring_d  = '0;
    end else begin
      start_d = press[BTN_START];
      a_d     = press[BTN_A];
      clr_d   = press[BTN_CLR];
      b_d     = press[BTN_B] && (sel_q == MODE_TIMER);
      if (press[BTN_MODE]) sel_d = next_mode(sel_q);
      case (state_q)
        IDLE: begin
          if (timer_running && !timer_zero) state_d = ARMED;
        end
        ARMED: begin
          if (press[BTN_CLR] && (sel_q == MODE_TIMER)) begin
            state_d = IDLE;
          end else if (timer_zero) begin
            state_d = RINGING;
            ring_d  = '0;
            sel_d   = MODE_TIMER;
          end else if (!timer_running) begin
            state_d = IDLE;
          end
        end
        RINGING: begin
          if (tick) begin
            if (ring_q == RING_LAST) begin
              state_d = IDLE;
              ring_d  = '0;
            end else begin
              ring_d = ring_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state and registered output pulses.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      ring_q  <= '0;
      sel_q   <= MODE_CLOCK;
      state_q <= IDLE;
      start_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      ring_q  <= ring_d;
      sel_q   <= sel_d;
      state_q <= state_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clr_q   <= clr_d;
    end
  end

  assign sel     = sel_q;
  assign tick1s  = tick;
  assign start_p = start_q;
  assign a_p     = a_q;
  assign b_p     = b_q;
  assign clr_p   = clr_q;
  assign ringing = (state_q == RINGING);
  assign alarm   = ringing && (pre_q < PRE_HALF);

endmodule

// File: doc/watch_ctrl.md
Name: watch_ctrl

Overview:
Single-clock front-end controller for the watch. It synchronizes and debounces the pushbuttons and generates the 1 Hz tick enable. It owns the display mode select (clock / stopwatch / timer), routes one-cycle button pulses to the mode blocks, and runs the countdown-expiry alarm FSM. It sits between the board buttons and the clock, stopwatch and timer datapaths, and drives their shared sel bus.

Parameters:
CLK_HZ, 100000000, clk100MHz frequency; prescaler terminal count is CLK_HZ-1
DEBOUNCE_CYCLES, 1000000, cycles a synchronized button must be stable before its debounced level changes
ALARM_SECS, 10, seconds the alarm rings before auto-stop

Ports:
clk100MHz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  raw button: cycle display mode
btn_start  in  1  raw button: start/pause
btn_a  in  1  raw button: +5 s in timer mode, lap in stopwatch mode
btn_b  in  1  raw button: +1 min in timer mode
btn_clr  in  1  raw button: clear the active mode
timer_zero  in  1  timer datapath reads 00:00
timer_running  in  1  timer datapath is counting
sel  out  2  mode: 00 clock, 01 stopwatch, 10 timer; 11 is never driven
tick1s  out  1  one-cycle pulse every CLK_HZ cycles
start_p  out  1  one-cycle start/pause pulse to the selected mode
a_p  out  1  one-cycle btn_a pulse to the selected mode
b_p  out  1  one-cycle btn_b pulse, emitted only when sel=10
clr_p  out  1  one-cycle clear pulse to the selected mode
alarm  out  1  beeper drive, 1 Hz square wave while ringing
ringing  out  1  alarm FSM is in RINGING

Behaviour:
- Reset: all outputs 0, sel=00, prescaler=0, debouncers cleared to level 0, FSM in IDLE.
- Input conditioning: each btn passes through a 2-flop synchronizer, then a debounce counter.
  - Counter clears whenever the synced value equals the debounced level.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES-1.
  - Rising edge of the debounced level gives a one-cycle internal press.
  - Latency from a stable raw edge to press: 2 + DEBOUNCE_CYCLES cycles, ±1.
- Prescaler: counts 0..CLK_HZ-1 and wraps.
  - tick1s=1 in the cycle the count equals CLK_HZ-1.
  - First tick is CLK_HZ cycles after reset release.
  - Prescaler is never cleared except by reset.
- Mode:
  - A mode press advances sel 00→01→10→00, registered, effective the next cycle.
  - Other presses in the same cycle route under the old sel.
- Routing, all outputs registered with one cycle latency from the press:
  - start_p, a_p, clr_p assert on their presses in any mode.
  - b_p asserts only when sel=10; otherwise the press is dropped.
  - Simultaneous presses of different buttons are all forwarded in the same cycle.
- Alarm FSM states:
  - IDLE → ARMED when timer_running=1 and timer_zero=0.
  - ARMED → IDLE on a clr press with sel=10, or when timer_running falls while timer_zero=0 (pause).
  - ARMED → RINGING when timer_zero=1.
  - RINGING → IDLE after ALARM_SECS tick1s pulses, counted from entry; or on any press of any button (acknowledge).
- Alarm outputs:
  - On RINGING entry, sel is forced to 10.
  - An acknowledging press is consumed: no routed pulse and no mode change.
  - alarm = ringing AND (prescaler < CLK_HZ/2).
  - ringing deasserts the cycle after exit.
- Reset mid-ring clears the FSM, alarm and sel immediately (asynchronous).
- The ring-second counter is wide enough for ALARM_SECS. The prescaler width is $clog2(CLK_HZ).

Decomposition:
- Package watch_pkg: mode encodings MODE_CLOCK=2'b00, MODE_STOPW=2'b01, MODE_TIMER=2'b10; alarm state enum IDLE/ARMED/RINGING.
- Sub-module btn_conditioner (parameter DEBOUNCE_CYCLES): synchronizer, debouncer and rise-pulse. Instantiated 5×.

Test Plan (CLK_HZ=10, DEBOUNCE_CYCLES=4, ALARM_SECS=3):
- Release reset, idle → tick1s high at cycles 10, 20, 30 after release; all other outputs 0; sel=00.
- btn_mode held 8 cycles, three times → sel 01, 10, 00. A 2-cycle glitch on btn_mode → no change.
- sel=00: press btn_b → no b_p. sel=10: press btn_b → single b_p pulse. btn_start and btn_a pressed in the same cycle → start_p and a_p in the same cycle.
- sel=01, timer_running=1, timer_zero=0, then timer_zero=1 → ringing=1, sel=10, alarm toggles every 5 cycles; ringing clears after 3 ticks.
- While ringing, press btn_mode → ringing=0, sel stays 10, no pulses emitted.
- rst_n low during RINGING → ringing=0, alarm=0, sel=00 without waiting for a clock edge.
